fp_normalize_pack: RTL



---
 rtl/fp_normalize_pack_pkg.sv | 59 +++++
 rtl/fp_normalize_pack_if.sv | 28 ++
 rtl/fp_round_ne.sv | 44 ++++
 rtl/fp_normalize_pack.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/fp_normalize_pack_pkg.sv
// Shared definitions for the single-precision normalise/round/pack back end:
// field widths, mantissa bit positions, FSM state encoding and word helpers.
package fp_normalize_pack_pkg;

    localparam int EXP_W     = 8;
    localparam int FRAC_W    = 23;
    localparam int BIAS      = 127;
    localparam int MANT_W    = FRAC_W + 4;      // carry, hidden, fraction, guard, sticky
    localparam int WORD_W    = 1 + EXP_W + FRAC_W;
    localparam int EXP_INT_W = EXP_W + 1;       // one spare bit so exp+1 past 255 is visible
    localparam int KEEP_W    = MANT_W - 2;      // bits [CARRY:LSB] kept after rounding

    // Mantissa bit positions
    localparam int CARRY_BIT  = MANT_W - 1;     // 26
    localparam int HIDDEN_BIT = MANT_W - 2;     // 25
    localparam int FRAC_HI    = HIDDEN_BIT - 1; // 24
    localparam int LSB_BIT    = 2;
    localparam int GUARD_BIT  = 1;
    localparam int STICKY_BIT = 0;

    // Smallest normal unbiased exponent and its biased encoding (1)
    localparam int EMIN = 1 - BIAS;
    localparam logic [EXP_INT_W-1:0] EXP_NORM_MIN = EXP_INT_W'(EMIN + BIAS);

    localparam logic [EXP_W-1:0]  EXP_MAX  = 8'hFF;
    localparam logic [WORD_W-1:0] POS_INF  = 32'h7F80_0000;
    localparam logic [WORD_W-1:0] NEG_ZERO = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Signed infinity
    function automatic logic [WORD_W-1:0] inf_word(input logic sign);
        return POS_INF | {sign, 31'd0};
    endfunction

    // Signed zero
    function automatic logic [WORD_W-1:0] zero_word(input logic sign);
        logic [WORD_W-1:0] w;
        if (sign) begin
            w = NEG_ZERO;
        end else begin
            w = 32'h0000_0000;
        end
        return w;
    endfunction

    // Assemble an IEEE-754 single from its fields
    function automatic logic [WORD_W-1:0] pack_word(input logic sign,
                                                    input logic [EXP_W-1:0] exp_f,
                                                    input logic [FRAC_W-1:0] frac_f);
        return {sign, exp_f, frac_f};
    endfunction

endpackage

// File: rtl/fp_normalize_pack_if.sv
// Producer/consumer handshake bundle for the normalise/pack block.
// slave = the block itself, master = whoever feeds it and drains it.
interface fp_normalize_pack_if;
    import fp_normalize_pack_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic                  in_sign;
    logic [EXP_W-1:0]      in_exp;
    logic [MANT_W-1:0]     in_mant;
    logic                  out_valid;
    logic                  out_ready;
    logic [WORD_W-1:0]     out_result;
    logic                  out_zero;
    logic                  out_inexact;
    logic                  out_overflow;

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_inexact, out_overflow
    );

    modport master (
        output in_valid, in_sign, in_exp, in_mant, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_inexact, out_overflow
    );

endinterface

// File: rtl/fp_round_ne.sv
// Round-to-nearest-even on a normalised (or subnormal) extended mantissa.
// Purely combinational; handles post-round carry, subnormal promotion and
// overflow detection so the FSM only has to choose what to latch.
module fp_round_ne
    import fp_normalize_pack_pkg::*;
(
    input  logic [MANT_W-1:0]    mant_i,
    input  logic [EXP_INT_W-1:0] exp_i,
    output logic [MANT_W-1:0]    mant_o,
    output logic [EXP_INT_W-1:0] exp_o,
    output logic                 inexact_o,
    output logic                 overflow_o
);

    logic              lsb_s;
    logic              guard_s;
    logic              sticky_s;
    logic              round_up_s;
    logic [KEEP_W-1:0] sum_s;

    // Increment at the lsb when above half or exactly half with odd lsb
    always_comb begin
        lsb_s      = mant_i[LSB_BIT];
        guard_s    = mant_i[GUARD_BIT];
        sticky_s   = mant_i[STICKY_BIT];
        round_up_s = guard_s & (sticky_s | lsb_s);
        inexact_o  = guard_s | sticky_s;
        sum_s      = mant_i[CARRY_BIT:LSB_BIT] + {{(KEEP_W-1){1'b0}}, round_up_s};
        mant_o     = {sum_s, 2'b00};
        exp_o      = exp_i;
        if (sum_s[KEEP_W-1]) begin
            // 1.111..1 + ulp carried out: renormalise
            mant_o = {1'b0, sum_s[KEEP_W-1:1], 2'b00};
            exp_o  = exp_i + {{(EXP_INT_W-1){1'b0}}, 1'b1};
        end else if ((exp_i == {EXP_INT_W{1'b0}}) && sum_s[KEEP_W-2]) begin
            // Largest subnormal rounded up into the smallest normal
            exp_o = EXP_NORM_MIN;
        end else begin
            exp_o = exp_i;
        end
        overflow_o = (exp_o >= {1'b0, EXP_MAX});
    end

endmodule

// File: rtl/fp_normalize_pack.sv
// Iterative normaliser, round-to-nearest-even and IEEE-754 single packer.
// One operation in flight: IDLE -> SHIFT (one shift per cycle) -> ROUND -> DONE.
// out_valid rises one cycle after DONE is entered and holds until accepted.
module fp_normalize_pack
    import fp_normalize_pack_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    fp_normalize_pack_if.slave   bus
);

    state_t                 state_q, state_d;
    logic                   sign_q, sign_d;
    logic [EXP_INT_W-1:0]   exp_q, exp_d;
    logic [MANT_W-1:0]      mant_q, mant_d;
    logic                   inf_q, inf_d;
    logic [WORD_W-1:0]      result_q, result_d;
    logic                   zero_q, zero_d;
    logic                   inexact_q, inexact_d;
    logic                   overflow_q, overflow_d;
    logic                   out_valid_q, out_valid_d;

    logic                   in_ready_s;
    logic [MANT_W-1:0]      rnd_mant_s;
    logic [EXP_INT_W-1:0]   rnd_exp_s;
    logic                   rnd_inexact_s;
    logic                   rnd_overflow_s;

    fp_round_ne u_round (
        .mant_i     (mant_q),
        .exp_i      (exp_q),
        .mant_o     (rnd_mant_s),
        .exp_o      (rnd_exp_s),
        .inexact_o  (rnd_inexact_s),
        .overflow_o (rnd_overflow_s)
    );

    assign in_ready_s       = (state_q == ST_IDLE) && !rst;
    assign bus.in_ready     = in_ready_s;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_result   = result_q;
    assign bus.out_zero     = zero_q;
    assign bus.out_inexact  = inexact_q;
    assign bus.out_overflow = overflow_q;

    // Next-state and datapath: capture, one normalise step, round, hold result
    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        exp_d       = exp_q;
        mant_d      = mant_q;
        inf_d       = inf_q;
        result_d    = result_q;
        zero_d      = zero_q;
        inexact_d   = inexact_q;
        overflow_d  = overflow_q;
        out_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_s) begin
                    sign_d     = bus.in_sign;
                    exp_d      = {1'b0, bus.in_exp};
                    mant_d     = bus.in_mant;
                    inf_d      = (bus.in_exp == EXP_MAX);
                    result_d   = {WORD_W{1'b0}};
                    zero_d     = 1'b0;
                    inexact_d  = 1'b0;
                    overflow_d = 1'b0;
                    state_d    = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (mant_q == {MANT_W{1'b0}}) begin
                    result_d = zero_word(sign_q);
                    zero_d   = 1'b1;
                    state_d  = ST_DONE;
                end else if (inf_q) begin
                    result_d   = inf_word(sign_q);
                    overflow_d = 1'b1;
                    state_d    = ST_DONE;
                end else if (mant_q[CARRY_BIT]) begin
                    // Fold the bit shifted out into sticky
                    mant_d  = {1'b0, mant_q[CARRY_BIT:LSB_BIT],
                               mant_q[GUARD_BIT] | mant_q[STICKY_BIT]};
                    exp_d   = exp_q + {{(EXP_INT_W-1){1'b0}}, 1'b1};
                    state_d = ST_ROUND;
                end else if (mant_q[HIDDEN_BIT]) begin
                    state_d = ST_ROUND;
                end else if (exp_q <= EXP_NORM_MIN) begin
                    // Cannot shift further without leaving the exponent range
                    exp_d   = {EXP_INT_W{1'b0}};
                    state_d = ST_ROUND;
                end else begin
                    mant_d  = {mant_q[CARRY_BIT-1:0], 1'b0};
                    exp_d   = exp_q - {{(EXP_INT_W-1){1'b0}}, 1'b1};
                    state_d = ST_SHIFT;
                end
            end
            ST_ROUND: begin
                mant_d    = rnd_mant_s;
                exp_d     = rnd_exp_s;
                inexact_d = rnd_inexact_s;
                if (rnd_overflow_s) begin
                    result_d   = inf_word(sign_q);
                    overflow_d = 1'b1;
                end else begin
                    result_d   = pack_word(sign_q, rnd_exp_s[EXP_W-1:0],
                                           rnd_mant_s[FRAC_HI:LSB_BIT]);
                    overflow_d = 1'b0;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; synchronous reset aborts any operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sign_q      <= 1'b0;
            exp_q       <= {EXP_INT_W{1'b0}};
            mant_q      <= {MANT_W{1'b0}};
            inf_q       <= 1'b0;
            result_q    <= {WORD_W{1'b0}};
            zero_q      <= 1'b0;
            inexact_q   <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            mant_q      <= mant_d;
            inf_q       <= inf_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            inexact_q   <= inexact_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
